// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared flag indices and entry types for the ALU result path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int ALU_BUS = 8;

  typedef logic [3:0] alu_flags_t;

  typedef struct packed {
    alu_flags_t           flags;
    logic [ALU_BUS-1:0]   result;
  } alu_entry_t;

endpackage

`default_nettype wire

// File: rtl/alu_sticky_reg.sv
// ============================================================================
// Module   : alu_sticky_reg
// Brief    : Sticky OR of accepted ALU flags; a clear colliding with a push
//            keeps the pushed flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_sticky_reg
  import alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       push_i,
  input  alu_flags_t flags_i,
  output alu_flags_t sticky_o
);

  alu_flags_t r_sticky;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sticky <= '0;
    end else if (clr_i && push_i) begin
      r_sticky <= flags_i;
    end else if (clr_i) begin
      r_sticky <= '0;
    end else if (push_i) begin
      r_sticky <= r_sticky | flags_i;
    end
  end

  assign sticky_o = r_sticky;

endmodule

`default_nettype wire

// File: rtl/alu_result_fifo.sv
// ============================================================================
// Module   : alu_result_fifo
// Brief    : First-word-fall-through FIFO of ALU results and flags with a
//            valid/ready interface and a sticky flag summary.
// Options  : ALU_RESULT_FIFO_OVF_EN adds ovf_o / drop_cnt_o overflow reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_result_fifo
  import alu_pkg::*;
#(
  parameter  int BUS   = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [BUS-1:0]   result_i,
  input  alu_flags_t       flags_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [BUS-1:0]   result_o,
  output alu_flags_t       flags_o,
  output logic [CNT_W-1:0] count_o,
  input  logic             sticky_clr_i,
  output alu_flags_t       sticky_flags_o
`ifdef ALU_RESULT_FIFO_OVF_EN
  ,
  output logic             ovf_o,
  output logic [7:0]       drop_cnt_o
`endif
);

  localparam int C_PTR_W = $clog2(DEPTH);

  typedef struct packed {
    alu_flags_t     flags;
    logic [BUS-1:0] result;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Handshake flags come only from the registered count, so ready_o never
  // depends combinationally on ready_i.
  assign w_ready = (r_count != CNT_W'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_push  = valid_i & w_ready;
  assign w_pop   = w_valid & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{flags: flags_i, result: result_i};
        r_wr_ptr        <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign ready_o  = w_ready;
  assign valid_o  = w_valid;
  assign result_o = r_mem[r_rd_ptr].result;
  assign flags_o  = r_mem[r_rd_ptr].flags;
  assign count_o  = r_count;

  alu_sticky_reg u_sticky (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (sticky_clr_i),
    .push_i   (w_push),
    .flags_i  (flags_i),
    .sticky_o (sticky_flags_o)
  );

`ifdef ALU_RESULT_FIFO_OVF_EN
  logic       r_ovf;
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop = valid_i & ~w_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_ovf <= w_drop;
      if (sticky_clr_i) begin
        r_drop_cnt <= '0;
      end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign ovf_o      = r_ovf;
  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
// ============================================================================
// Module   : tb_alu_result_fifo
// Brief    : Directed self-checking bench for alu_result_fifo.
// Options  : exercises ovf_o / drop_cnt_o when ALU_RESULT_FIFO_OVF_EN is set.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int BUS   = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             valid_i;
  logic             ready_o;
  logic [BUS-1:0]   result_i;
  alu_flags_t       flags_i;
  logic             valid_o;
  logic             ready_i;
  logic [BUS-1:0]   result_o;
  alu_flags_t       flags_o;
  logic [CNT_W-1:0] count_o;
  logic             sticky_clr_i;
  alu_flags_t       sticky_flags_o;
`ifdef ALU_RESULT_FIFO_OVF_EN
  logic             ovf_o;
  logic [7:0]       drop_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  alu_result_fifo #(.BUS(BUS), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .result_i       (result_i),
    .flags_i        (flags_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .result_o       (result_o),
    .flags_o        (flags_o),
    .count_o        (count_o),
    .sticky_clr_i   (sticky_clr_i),
    .sticky_flags_o (sticky_flags_o)
`ifdef ALU_RESULT_FIFO_OVF_EN
    ,
    .ovf_o          (ovf_o),
    .drop_cnt_o     (drop_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hold(input logic [7:0] r, input alu_flags_t f);
    valid_i  = 1'b1;
    result_i = r;
    flags_i  = f;
    tick();
  endtask

  logic [7:0] exp_seq [5];

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; result_i = '0; flags_i = '0;
    sticky_clr_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_valid",  32'(valid_o), 32'd0);
    check("rst_ready",  32'(ready_o), 32'd1);
    check("rst_count",  32'(count_o), 32'd0);
    check("rst_result", 32'(result_o), 32'd0);
    check("rst_flags",  32'(flags_o), 32'd0);
    check("rst_sticky", 32'(sticky_flags_o), 32'd0);

    // Single pass-through
    ready_i = 1'b1;
    push_hold(8'h80, 4'b0010);
    valid_i = 1'b0;
    check("pt_valid",  32'(valid_o), 32'd1);
    check("pt_result", 32'(result_o), 32'h80);
    check("pt_flags",  32'(flags_o), 32'd2);
    check("pt_count",  32'(count_o), 32'd1);
    tick();
    check("pt_count0", 32'(count_o), 32'd0);
    check("pt_valid0", 32'(valid_o), 32'd0);
    check("pt_sticky", 32'(sticky_flags_o), 32'b0010);

    // Fill and wrap
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) push_hold(8'(i), 4'b0000);
    check("fill_count", 32'(count_o), 32'd4);
    check("fill_ready", 32'(ready_o), 32'd0);
    push_hold(8'h05, 4'b0000);
    check("held_count", 32'(count_o), 32'd4);
    check("held_head",  32'(result_o), 32'h01);
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h03;
    exp_seq[3] = 8'h04; exp_seq[4] = 8'h05;
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("wrap_valid%0d", k), 32'(valid_o), 32'd1);
      check($sformatf("wrap_head%0d", k), 32'(result_o), 32'(exp_seq[k]));
      tick();
      if (k == 0) check("wrap_cnt_after_pop", 32'(count_o), 32'd3);
      if (k == 1) begin
        check("wrap_cnt_after_pushpop", 32'(count_o), 32'd3);
        valid_i = 1'b0;
      end
    end
    check("wrap_empty", 32'(count_o), 32'd0);

    // Simultaneous push/pop at count 2
    ready_i = 1'b0;
    push_hold(8'h11, 4'b0000);
    push_hold(8'h22, 4'b0000);
    check("pp_count2", 32'(count_o), 32'd2);
    ready_i = 1'b1;
    push_hold(8'h33, 4'b0000);
    check("pp_count_a", 32'(count_o), 32'd2);
    check("pp_head_a",  32'(result_o), 32'h22);
    push_hold(8'h44, 4'b0000);
    check("pp_count_b", 32'(count_o), 32'd2);
    check("pp_head_b",  32'(result_o), 32'h33);
    valid_i = 1'b0;
    tick();
    check("pp_head_c",  32'(result_o), 32'h44);
    tick();
    check("pp_empty",   32'(count_o), 32'd0);

    // Sticky register
    sticky_clr_i = 1'b1;
    tick();
    sticky_clr_i = 1'b0;
    check("st_clr0", 32'(sticky_flags_o), 32'd0);
    push_hold(8'h55, 4'b1000);
    valid_i = 1'b0;
    check("st_v", 32'(sticky_flags_o), 32'b1000);
    sticky_clr_i = 1'b1;
    push_hold(8'h66, 4'b0001);
    valid_i = 1'b0;
    check("st_clr_push", 32'(sticky_flags_o), 32'b0001);
    tick();
    sticky_clr_i = 1'b0;
    check("st_clr_alone", 32'(sticky_flags_o), 32'd0);
    tick();

    // Reset asserted mid-stream
    ready_i = 1'b0;
    push_hold(8'hA1, 4'b0100);
    push_hold(8'hA2, 4'b0100);
    valid_i = 1'b0;
    check("mid_count", 32'(count_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_valid",  32'(valid_o), 32'd0);
    check("mid_count0", 32'(count_o), 32'd0);
    check("mid_ready",  32'(ready_o), 32'd1);
    check("mid_sticky", 32'(sticky_flags_o), 32'd0);
    check("mid_result", 32'(result_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();

`ifdef ALU_RESULT_FIFO_OVF_EN
    for (int i = 0; i < 4; i++) push_hold(8'(8'hB0 + i), 4'b0000);
    check("ovf_idle",  32'(ovf_o), 32'd0);
    check("ovf_drop0", 32'(drop_cnt_o), 32'd0);
    valid_i = 1'b1; result_i = 8'hBF;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("ovf_pulse%0d", i), 32'(ovf_o), 32'd1);
      check($sformatf("ovf_drop%0d", i), 32'(drop_cnt_o), 32'(i));
    end
    valid_i = 1'b0;
    tick();
    check("ovf_low",   32'(ovf_o), 32'd0);
    check("ovf_drop3", 32'(drop_cnt_o), 32'd3);
    sticky_clr_i = 1'b1;
    tick();
    sticky_clr_i = 1'b0;
    check("ovf_clr",   32'(drop_cnt_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
